// File: rtl/merge_rr_oehb_pkg.sv
// Shared types and width helpers for the round-robin merge with a one-slot output register.
package merge_rr_oehb_pkg;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        int unsigned x;
        r = 0;
        x = 1;
        while (x < v) begin
            x = x << 1;
            r = r + 1;
        end
        return r;
    endfunction

    // Index width never collapses to zero, so a single-input merge still has a 1-bit index.
    function automatic int unsigned index_w(input int unsigned n);
        return (n <= 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/merge_rr_oehb_rr_arbiter.sv
// Combinational round-robin arbiter: priority scan of the request vector rotated so ptr is lowest.
module rr_arbiter
    import merge_rr_oehb_pkg::*;
#(
    parameter  int unsigned N  = 2,
    localparam int unsigned IW = index_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          any
);

    localparam int unsigned SW = IW + 1;

    logic [2*N-1:0] req_dbl;
    logic [N-1:0]   req_rot;
    logic [IW-1:0]  offset;
    logic [SW-1:0]  idx_sum;

    // Lowest set bit of the rotated vector is the first requester at or after ptr.
    always_comb begin
        req_dbl = {req, req};
        req_rot = N'(req_dbl >> ptr);
        any     = 1'b0;
        offset  = '0;
        for (int k = int'(N) - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                any    = 1'b1;
                offset = IW'(k);
            end
        end
        idx_sum = SW'(ptr) + SW'(offset);
        if (idx_sum >= SW'(N)) begin
            idx_sum = idx_sum - SW'(N);
        end
        grant_idx = IW'(idx_sum);
        grant     = any ? (N'(1) << grant_idx) : '0;
    end

endmodule

// File: rtl/merge_rr_oehb.sv
// Round-robin merge of INPUTS dataflow channels into a one-slot registered output (OEHB style).
module merge_rr_oehb
    import merge_rr_oehb_pkg::*;
#(
    parameter  int unsigned INPUTS    = 2,
    parameter  int unsigned DATA_TYPE = 32,
    localparam int unsigned INDEX_W   = index_w(INPUTS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [INPUTS*DATA_TYPE-1:0]   ins,
    input  logic [INPUTS-1:0]             ins_valid,
    output logic [INPUTS-1:0]             ins_ready,
    output logic [DATA_TYPE-1:0]          outs,
    output logic [INDEX_W-1:0]            outs_index,
    output logic                          outs_valid,
    input  logic                          outs_ready
);

    slot_state_t          state;
    slot_state_t          state_nxt;
    logic [INDEX_W-1:0]   ptr;
    logic [INDEX_W-1:0]   ptr_nxt;
    logic [DATA_TYPE-1:0] outs_nxt;
    logic [INDEX_W-1:0]   index_nxt;
    logic [DATA_TYPE-1:0] data_sel;
    logic [INPUTS-1:0]    grant;
    logic [INDEX_W-1:0]   grant_idx;
    logic                 any_req;
    logic                 load_en;
    logic                 take;

    rr_arbiter #(.N(INPUTS)) u_arb (
        .req       (ins_valid),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (any_req)
    );

    // AND-OR mux: lanes without a grant are masked, so their contents never reach the slot.
    always_comb begin
        data_sel = '0;
        for (int i = 0; i < int'(INPUTS); i++) begin
            data_sel = data_sel | (ins[i*DATA_TYPE +: DATA_TYPE] & {DATA_TYPE{grant[i]}});
        end
    end

    assign outs_valid = (state == SLOT_FULL);
    assign load_en    = !outs_valid || outs_ready;
    assign ins_ready  = grant & {INPUTS{load_en}};
    assign take       = any_req && load_en;

    // Slot next-state plus payload and pointer update on a transfer.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        outs_nxt  = outs;
        index_nxt = outs_index;
        case (state)
            SLOT_EMPTY: if (any_req) state_nxt = SLOT_FULL;
            SLOT_FULL:  if (outs_ready && !any_req) state_nxt = SLOT_EMPTY;
        endcase
        if (take) begin
            outs_nxt  = data_sel;
            index_nxt = grant_idx;
            ptr_nxt   = (grant_idx == INDEX_W'(INPUTS - 1)) ? '0 : grant_idx + INDEX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= SLOT_EMPTY;
            ptr        <= '0;
            outs       <= '0;
            outs_index <= '0;
        end else begin
            state      <= state_nxt;
            ptr        <= ptr_nxt;
            outs       <= outs_nxt;
            outs_index <= index_nxt;
        end
    end

endmodule
